// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // One decoded-ready instruction: its word address and the fetched data.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    // Width needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/response and decode-side handshake bundle for the fetch unit.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    // Memory / decode side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a clear that wins over push and pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; clear empties the queue in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues reads at the PC, pairs in-order responses with their
// addresses, buffers them for decode and discards in-flight work on flush.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W          = fetch_pkg::ADDR_W,
    parameter int DATA_W          = fetch_pkg::DATA_W,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    input  logic              flush,
    instr_fetch_unit_if.master bus
);
    localparam int CW  = cnt_w(MAX_OUTSTANDING);
    localparam int OCW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]  live, drop;
    logic [OCW-1:0] oq_count, aq_count;
    logic           oq_full, oq_empty, aq_full, aq_empty;
    logic [ADDR_W-1:0] aq_head;
    fetch_entry_t   rsp_entry, oq_head;
    logic           issue, accept, rsp_live, rsp_drop, if_pop;

    // Address-queue occupancy tracks live exactly; it bounds buffer credits
    // so a response always finds room in the output queue.
    assign issue = !flush && !aq_full
                 && (int'(oq_count) + int'(aq_count) < FIFO_DEPTH)
                 && (int'(live) + int'(drop) < MAX_OUTSTANDING);

    assign bus.imem_req_valid = issue && !reset;
    assign bus.imem_req_addr  = pc_in;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign pc_advance         = accept;

    // Responses owed from before a flush are consumed first.
    assign rsp_drop = bus.imem_rsp_valid && (drop != '0);
    assign rsp_live = bus.imem_rsp_valid && (drop == '0) && !flush && !aq_empty;
    assign if_pop   = !oq_empty && bus.if_ready && !flush;

    // Pair the response with the oldest outstanding address.
    always_comb begin
        rsp_entry       = '0;
        rsp_entry.pc    = aq_head;
        rsp_entry.instr = bus.imem_rsp_data;
    end

    // Live/drop bookkeeping; flush converts all live requests into drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live <= '0;
            drop <= '0;
        end else if (flush) begin
            live <= '0;
            drop <= drop + live - CW'(bus.imem_rsp_valid);
        end else begin
            live <= live + CW'(accept) - CW'(rsp_live);
            drop <= drop - CW'(rsp_drop);
        end
    end

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_addr_q (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (rsp_live),
        .clear (flush),
        .din   (pc_in),
        .full  (aq_full),
        .empty (aq_empty),
        .count (aq_count),
        .head  (aq_head)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_out_q (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_live && !oq_full),
        .pop   (if_pop),
        .clear (flush),
        .din   (rsp_entry),
        .full  (oq_full),
        .empty (oq_empty),
        .count (oq_count),
        .head  (oq_head)
    );

    assign bus.if_valid = !oq_empty;
    assign bus.if_pc    = oq_head.pc;
    assign bus.if_instr = oq_head.instr;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based reference model.
module tb_instr_fetch_unit;
    localparam int AW = 32, DW = 32, DEPTH = 4, MAXO = 4;

    logic          clk = 1'b0, reset = 1'b1, flush = 1'b0, pc_advance;
    logic [AW-1:0] pc_in = '0, flush_tgt = '0;

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, mem_lat = 1;

    typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
    typedef struct { logic [AW-1:0] addr; bit doomed; } infl_t;
    typedef struct { logic [AW-1:0] pc; logic [DW-1:0] instr; } ent_t;
    typedef struct { logic [AW-1:0] pc; logic [DW-1:0] instr; int cyc; } dlv_t;

    mreq_t         memq[$];
    infl_t         infl[$];
    ent_t          expq[$];
    dlv_t          dlv[$];
    logic [AW-1:0] acc_log[$];

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outstanding requests, with flush marking them doomed,
    // and a queue of instructions owed to decode.
    always @(negedge clk) begin
        int   live_n;
        bit   exp_req;
        infl_t h;
        if (reset) begin
            infl.delete();
            expq.delete();
            chk("rst_req_valid", bus.imem_req_valid, 0);
            chk("rst_pc_advance", pc_advance, 0);
            chk("rst_if_valid", bus.if_valid, 0);
        end else begin
            live_n = 0;
            foreach (infl[i]) if (!infl[i].doomed) live_n++;
            exp_req = !flush && (expq.size() + live_n < DEPTH) && (infl.size() < MAXO);
            chk("req_valid", bus.imem_req_valid, exp_req);
            if (exp_req) chk("req_addr", bus.imem_req_addr, pc_in);
            chk("pc_advance", pc_advance, exp_req && bus.imem_req_ready);
            chk("if_valid", bus.if_valid, expq.size() != 0);
            if (expq.size() != 0) begin
                chk("if_pc", bus.if_pc, expq[0].pc);
                chk("if_instr", bus.if_instr, expq[0].instr);
            end
            if (expq.size() != 0 && bus.if_ready && !flush) begin
                dlv.push_back('{expq[0].pc, expq[0].instr, cyc});
                void'(expq.pop_front());
            end
            if (flush) begin
                expq.delete();
                foreach (infl[i]) infl[i].doomed = 1'b1;
            end
            if (bus.imem_rsp_valid) begin
                if (infl.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_outstanding: response with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    h = infl.pop_front();
                    if (!h.doomed && !flush) begin
                        chk("outq_has_room", expq.size() < DEPTH, 1);
                        expq.push_back('{h.addr, bus.imem_rsp_data});
                    end
                end
            end
            if (exp_req && bus.imem_req_ready) begin
                infl.push_back('{pc_in, 1'b0});
                acc_log.push_back(pc_in);
            end
        end
    end

    // One clock: memory model and program counter react to the finished cycle.
    task automatic tick();
        logic [AW-1:0] pc_nxt;
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_ready && !reset)
            memq.push_back('{bus.imem_req_addr, cyc + mem_lat});
        pc_nxt = reset ? pc_in : flush ? flush_tgt : pc_advance ? pc_in + 1 : pc_in;
        @(posedge clk);
        cyc++;
        #1;
        pc_in = pc_nxt;
        if (reset) memq.delete();
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [AW-1:0] start);
        reset = 1'b1;
        flush = 1'b0;
        pc_in = start;
        ticks(2);
        pc_in = start;
        reset = 1'b0;
        dlv.delete();
        acc_log.delete();
        t0 = cyc;
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b1;

        // Streaming at latency 1.
        mem_lat = 1;
        do_reset(0);
        ticks(12);
        chk("s_count", dlv.size() >= 8, 1);
        if (dlv.size() >= 8 && acc_log.size() >= 8) begin
            chk("s_instr0", dlv[0].instr, 32'hC0DE0000);
            chk("s_instr1", dlv[1].instr, 32'h5EE979B1);
            for (int i = 0; i < 8; i++) begin
                chk("s_pc", dlv[i].pc, i);
                chk("s_cycle", dlv[i].cyc, t0 + 2 + i);
                chk("s_acc", acc_log[i], i);
            end
        end

        // Decode backpressure fills the buffer with exactly four requests.
        bus.if_ready = 1'b0;
        do_reset(0);
        ticks(6);
        chk("bp_accepts", acc_log.size(), 4);
        chk("bp_req_valid", bus.imem_req_valid, 0);
        bus.if_ready = 1'b1;
        ticks(8);
        if (dlv.size() >= 4 && acc_log.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk("bp_pop_pc", dlv[i].pc, i);
            chk("bp_resume", acc_log[4], 4);
        end else chk("bp_progress", 0, 1);

        // Memory not ready: request held stable.
        bus.imem_req_ready = 1'b0;
        do_reset(32'h10);
        ticks(5);
        chk("st_accepts", acc_log.size(), 0);
        chk("st_req_valid", bus.imem_req_valid, 1);
        chk("st_addr", bus.imem_req_addr, 32'h10);
        chk("st_pc_adv", pc_advance, 0);
        bus.imem_req_ready = 1'b1;
        tick();
        chk("st_single", acc_log.size(), 1);
        if (acc_log.size() >= 1) chk("st_addr_acc", acc_log[0], 32'h10);

        // Flush with two requests in flight at latency 3.
        mem_lat = 3;
        do_reset(0);
        ticks(2);
        flush = 1'b1;
        flush_tgt = 32'h40;
        tick();
        flush = 1'b0;
        ticks(8);
        if (dlv.size() >= 1) begin
            chk("fl_pc", dlv[0].pc, 32'h40);
            chk("fl_instr", dlv[0].instr, instr_of(32'h40));
            chk("fl_cycle", dlv[0].cyc, t0 + 7);
        end else chk("fl_delivered", 0, 1);

        // Flush coinciding with a response and a decode pop, latency 2.
        mem_lat = 2;
        do_reset(0);
        ticks(5);
        chk("fc_pre_valid", bus.if_valid, 1);
        flush = 1'b1;
        flush_tgt = 32'h80;
        tick();
        flush = 1'b0;
        chk("fc_post_valid", bus.if_valid, 0);
        dlv.delete();
        ticks(6);
        if (dlv.size() >= 1) begin
            chk("fc_pc", dlv[0].pc, 32'h80);
            chk("fc_cycle", dlv[0].cyc, t0 + 9);
        end else chk("fc_delivered", 0, 1);

        // Asynchronous reset with buffered entries.
        mem_lat = 1;
        bus.if_ready = 1'b0;
        do_reset(0);
        ticks(4);
        chk("rm_pre_valid", bus.if_valid, 1);
        reset = 1'b1;
        #1;
        chk("rm_req_valid", bus.imem_req_valid, 0);
        chk("rm_pc_adv", pc_advance, 0);
        chk("rm_if_valid", bus.if_valid, 0);
        bus.if_ready = 1'b1;
        do_reset(32'h20);
        ticks(6);
        if (dlv.size() >= 1 && acc_log.size() >= 1) begin
            chk("rm_acc", acc_log[0], 32'h20);
            chk("rm_pc", dlv[0].pc, 32'h20);
            chk("rm_cycle", dlv[0].cyc, t0 + 2);
        end else chk("rm_restart", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Issues instruction-memory reads at the current PC and pulses the PC increment on each accepted request.
- Pairs in-order memory responses with their issue addresses and buffers them for decode over a valid/ready interface.
- Handles pipeline flush (branch redirect) by discarding every response still in flight.

Parameters:
ADDR_W, 32, PC / memory word-address width (PC is word-addressed, +1 per instruction)
DATA_W, 32, instruction width
FIFO_DEPTH, 4, output buffer entries; also bounds live outstanding requests (power of 2, >=2)
MAX_OUTSTANDING, 4, cap on total in-flight requests, live plus pending-drop

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pc_in  in  ADDR_W  current PC from the program counter
pc_advance  out  1  one-cycle pulse, drives the PC inc input
flush  in  1  redirect; the PC loads the branch target the same cycle
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  read address
imem_rsp_valid  in  1  read data valid; in order, cannot be back-pressured
imem_rsp_data  in  DATA_W  read data
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_pc  out  ADDR_W  PC of presented instruction
if_instr  out  DATA_W  presented instruction

Behaviour:
- Reset (clk = clk, reset = reset, asynchronous, active-high): both queues empty; live and drop counters 0; imem_req_valid, pc_advance and if_valid all 0. Reset mid-operation abandons everything; responses arriving after reset deasserts are the memory's responsibility.
- Counters:
  - live = requests issued since the last flush, response not yet received.
  - drop = responses owed from before a flush.
  - Width $clog2(MAX_OUTSTANDING+1). Neither counter may underflow or overflow.
- Issue condition (combinational): !flush && (out_count + live < FIFO_DEPTH) && (live + drop < MAX_OUTSTANDING).
  - imem_req_valid = issue condition; imem_req_addr = pc_in.
- Handshake:
  - Request accepted when imem_req_valid && imem_req_ready.
  - On accept: pc_advance = 1 the same cycle, pc_in pushed to the address queue, live += 1.
  - imem_req_valid deasserts without a handshake only on flush. Credits never shrink otherwise, so valid and addr stay stable while ready is low.
- Response with drop > 0: data discarded, drop -= 1.
- Response with drop == 0:
  - Pop the address-queue head and push {head, data} into the output queue; live -= 1.
  - By construction the output queue is never full here. A bench assertion checks this.
- Output:
  - if_valid = output queue non-empty; if_pc and if_instr = head.
  - Pop on if_valid && if_ready && !flush.
  - Response at cycle N is visible at cycle N+1. Minimum issue-to-if_valid latency = memory latency + 1.
- Flush cycle:
  - No issue; pc_advance = 0.
  - Output queue and address queue cleared; a same-cycle pop is ignored.
  - drop_next = drop + live - (imem_rsp_valid ? 1 : 0); live_next = 0.
  - A response arriving in the flush cycle is discarded.
  - The first post-flush request goes out the next cycle at the redirected pc_in.
- Simultaneous issue and response: live unchanged; address queue push and pop together.
- Back-to-back flushes: accumulate into drop correctly.

Decomposition:
- Package fetch_pkg:
  - ADDR_W and DATA_W defaults.
  - fetch_entry_t packed struct {pc, instr}.
  - Counter width function.
- Sub-module fetch_fifo:
  - Synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, clear, full, empty, count, head.
  - Async reset; clear has priority over push and pop.
  - Instantiated twice: address queue (ADDR_W) and output queue (fetch_entry_t).

Test Plan:
- Stream: memory latency 1, ready always 1, if_ready=1, PC starts 0 -> one pc_advance per cycle; if_pc 0,1,2,...,7 with matching instr on consecutive cycles from cycle 2.
- Backpressure: if_ready=0, latency 1 -> exactly 4 accepts (addr 0..3), then imem_req_valid=0. Raise if_ready -> pops 0..3 in order; issue resumes at addr 4.
- Memory stall: imem_req_ready=0 for 5 cycles -> imem_req_valid held 1, addr constant, pc_advance 0 throughout; single accept when ready rises.
- Flush in flight: latency 3, flush with live=2 and pc_in redirected to 0x40 -> next 2 responses dropped, no if_valid. First delivered if_pc=0x40.
- Flush coincident with response and decode pop -> response discarded, queues empty next cycle, drop equals live-1. No stale if_valid afterwards.
- Reset asserted mid-stream with 3 entries buffered -> all outputs 0 immediately (async); after release, fetch restarts at pc_in with empty queues.
